uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the uart engine's rx interface (rx_data/rx_avail/rx_error/rx_ack) and upstream of the Wishbone UART register block. It drains each received byte from the engine with a one-cycle rx_ack pulse. Each byte and its error flag are stored in a 2^DEPTH_LOG2-entry FIFO. A show-ahead pop interface exposes the stored bytes, so software no longer loses bytes between polls.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries default); legal range 2..8
ALMOST_FULL, 12, level at or above which almost_full asserts; must be < 2^DEPTH_LOG2
TIMEOUT_CYCLES, 4096, idle cycles before rx_timeout asserts; used only with UART_RX_FIFO_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rx_data  in  8  received byte from uart engine
rx_avail  in  1  engine holds a valid byte; level signal, cleared by engine after rx_ack
rx_error  in  1  framing error flag for current byte
rx_ack  out  1  one-cycle pulse consuming the engine's byte
pop  in  1  consume head entry (single-cycle strobe)
dout  out  8  head byte (show-ahead)
dout_err  out  1  error flag stored with head byte
empty  out  1  FIFO holds no entries
full  out  1  FIFO holds 2^DEPTH_LOG2 entries
almost_full  out  1  level >= ALMOST_FULL
level  out  DEPTH_LOG2+1  current entry count
overflow  out  1  sticky: a byte was dropped because the FIFO was full
ovf_clr  in  1  clears overflow
rx_timeout  out  1  FIFO non-empty and idle for TIMEOUT_CYCLES (optional feature)

Behaviour:
- Reset (reset=0, async assert, sync release): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, almost_full=0, overflow=0, rx_ack=0, rx_timeout=0, capture FSM=IDLE. Storage RAM is not reset.
- Storage: 9-bit words {rx_error, rx_data}. Pointers are DEPTH_LOG2 bits and wrap naturally modulo depth. level is a separate (DEPTH_LOG2+1)-bit counter.
- Capture FSM states IDLE, WAIT:
  - IDLE and rx_avail=1: register rx_ack=1 for exactly one cycle, perform the push decision in the same cycle, go to WAIT.
  - WAIT: rx_ack=0; stay until rx_avail=0, then go to IDLE. This guards against double capture of one byte.
- Push decision:
  - If not full, or full with pop asserted in the same cycle: write {rx_error, rx_data} at wr_ptr, then increment wr_ptr.
  - Else the byte is acked and discarded, and overflow is set to 1.
- Pop: pop with empty=0 increments rd_ptr. pop with empty=1 is ignored, with no pointer or level change.
- Simultaneous push and pop: level is unchanged and both pointers advance. At level=0 only the push takes effect, because the pop is ignored while empty.
- Flags are registered, derived from next-state level. They are valid the cycle after the causing edge:
  - empty = (level==0)
  - full = (level==2^DEPTH_LOG2)
  - almost_full = (level>=ALMOST_FULL)
- dout/dout_err: combinational read of mem[rd_ptr]. Forced to 0 when empty=1.
- Latency: rx_avail rising to rx_ack is 1 cycle. rx_ack cycle to empty=0 and valid dout is 1 cycle.
- Overflow: set has priority over ovf_clr in the same cycle. Pop does not clear it.

Optional Feature:
UART_RX_FIFO_TIMEOUT_EN
- Defined: a 32-bit idle counter is cleared on any accepted push or effective pop, and when level==0. Otherwise it increments, saturating at TIMEOUT_CYCLES. rx_timeout is registered high when the count reaches TIMEOUT_CYCLES while level!=0. It is cleared by the next push or pop.
- Not defined: no counter is built; rx_timeout is tied 0.

Test Plan:
1. Reset mid-stream: push 3 bytes, assert reset=0 -> asynchronous clear: level=0, empty=1, overflow=0, rx_ack=0. A byte still pending on rx_avail after release is captured once.
2. Single byte: rx_data=0xA5, rx_avail held 5 cycles -> exactly one rx_ack pulse; one cycle later empty=0, dout=0xA5, dout_err=0, level=1. pop -> empty=1, dout=0.
3. Fill and wrap (DEPTH_LOG2=4): push 0x00..0x0F -> full=1, almost_full=1 from level 12. Pop 8, push 0x10..0x17 -> pops return 0x08..0x17 in order with no corruption across the pointer wrap.
4. Overflow: with full=1, present 0xEE -> rx_ack pulses, level stays 16, overflow=1, 0xEE is never popped. ovf_clr -> overflow=0. Set and clear in the same cycle -> overflow=1.
5. Simultaneous push and pop at full: pop asserted in the rx_ack cycle -> new byte stored, level stays 16, overflow stays 0. Pop on empty -> no change, level=0.
6. Error tag and timeout (macro defined, TIMEOUT_CYCLES=16): push 0x3C with rx_error=1, then idle -> dout_err=1; rx_timeout=1 after 16 idle cycles; pop -> rx_timeout=0. Macro undefined -> rx_timeout stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side buffer between the uart engine rx interface and the Wishbone
// UART register block. Each byte the engine presents is drained with a
// one-cycle rx_ack pulse and stored, together with its framing-error flag,
// in a 2^DEPTH_LOG2-entry FIFO that software reads through a show-ahead
// pop interface.
//
// Optional feature macro: UART_RX_FIFO_TIMEOUT_EN
//   defined   : idle counter drives o_rx_timeout
//   undefined : o_rx_timeout is tied 0, no counter is built
//
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous active-low reset
//   i_rx_data      received byte from the engine
//   i_rx_avail     engine holds a valid byte (level)
//   i_rx_error     framing error flag of the current byte
//   o_rx_ack       one-cycle pulse consuming the engine's byte
//   i_pop          consume head entry (single-cycle strobe)
//   o_dout         head byte (show-ahead), 0 when empty
//   o_dout_err     error flag stored with head byte, 0 when empty
//   o_empty        FIFO holds no entries
//   o_full         FIFO holds 2^DEPTH_LOG2 entries
//   o_almost_full  level >= ALMOST_FULL
//   o_level        current entry count
//   o_overflow     sticky: a byte was dropped because the FIFO was full
//   i_ovf_clr      clears o_overflow (a same-cycle drop wins)
//   o_rx_timeout   FIFO non-empty and idle for TIMEOUT_CYCLES
//   o_dbg_state    capture FSM state (0 = IDLE, 1 = WAIT)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2     = 4,
    parameter int ALMOST_FULL    = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_avail,
    input  logic                  i_rx_error,
    output logic                  o_rx_ack,
    input  logic                  i_pop,
    output logic [7:0]            o_dout,
    output logic                  o_dout_err,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_full,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow,
    input  logic                  i_ovf_clr,
    output logic                  o_rx_timeout,
    output logic                  o_dbg_state
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LP_AF    = (DEPTH_LOG2 + 1)'(ALMOST_FULL);

    // Engine handshake: the engine raises i_rx_avail and holds i_rx_data /
    // i_rx_error stable until it has seen o_rx_ack; it drops i_rx_avail
    // afterwards. The FIFO samples the byte during the o_rx_ack cycle, and
    // waits for i_rx_avail to fall before it may ack again, so a slow engine
    // can never have one byte captured twice.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ack_next;
    logic                  r_rx_ack;

    logic [8:0]            r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [DEPTH_LOG2:0]   w_level_next;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_overflow;

    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // Capture FSM: next state and ack request
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_avail) begin
                    w_ack_next   = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_rx_avail) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_rx_ack <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rx_ack <= w_ack_next;
        end
    end

    // The push decision is taken in the ack cycle. A full FIFO still accepts
    // the byte if a pop frees a slot in that same cycle.
    assign w_pop  = i_pop & ~r_empty;
    assign w_push = r_rx_ack & (~r_full | i_pop);
    assign w_drop = r_rx_ack & r_full & ~i_pop;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level       <= w_level_next;
            // Flags come from the next level so they line up with r_level.
            r_empty       <= (w_level_next == '0);
            r_full        <= (w_level_next == LP_DEPTH);
            r_almost_full <= (w_level_next >= LP_AF);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {i_rx_error, i_rx_data};
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam logic [31:0] LP_TMO = 32'(TIMEOUT_CYCLES);

    logic [31:0] r_idle_cnt;
    logic [31:0] w_idle_next;
    logic        r_rx_timeout;

    always_comb begin
        w_idle_next = r_idle_cnt;
        if (w_push || w_pop || (r_level == '0)) begin
            w_idle_next = '0;
        end else if (r_idle_cnt != LP_TMO) begin
            w_idle_next = r_idle_cnt + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idle_cnt   <= '0;
            r_rx_timeout <= 1'b0;
        end else begin
            r_idle_cnt <= w_idle_next;
            if (w_push || w_pop) begin
                r_rx_timeout <= 1'b0;
            end else if ((w_idle_next == LP_TMO) && (r_level != '0)) begin
                r_rx_timeout <= 1'b1;
            end
        end
    end

    assign o_rx_timeout = r_rx_timeout;
`else
    // Feature disabled: the comparison is constant false, so this is a tie-off.
    assign o_rx_timeout = (TIMEOUT_CYCLES < 0);
`endif

    assign o_rx_ack      = r_rx_ack;
    assign o_dout        = r_empty ? 8'h00 : r_mem[r_rd_ptr][7:0];
    assign o_dout_err    = r_empty ? 1'b0  : r_mem[r_rd_ptr][8];
    assign o_empty       = r_empty;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_level       = r_level;
    assign o_overflow    = r_overflow;
    assign o_dbg_state   = r_state;

endmodule
